// File: rtl/mouse_cmd_sequencer.sv
// PS/2 mouse command sequencer: sends a command byte (plus optional argument),
// waits for transmit-complete and the device ACK (0xFA), resends on 0xFE up to
// MAX_RETRY times per byte, and aborts with an error on timeout or a bad reply.
// Ports:
//   CLK, RESET                  clock and synchronous active-high reset
//   CMD_REQ/CMD_BYTE/ARG_BYTE/ARG_VALID   host request, sampled only in IDLE
//   CMD_BUSY/CMD_DONE/CMD_ERR   status; CMD_ERR only meaningful with CMD_DONE
//   SEND_BYTE/BYTE_TO_SEND/BYTE_SENT      transmitter handshake
//   BYTE_READY/BYTE_READ/BYTE_ERROR_CODE  receiver input
//   STREAM_HOLD                 mirrors CMD_BUSY for the packet assembler
module mouse_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_REQ,
  input  logic [7:0] CMD_BYTE,
  input  logic [7:0] ARG_BYTE,
  input  logic       ARG_VALID,
  output logic       CMD_BUSY,
  output logic       CMD_DONE,
  output logic       CMD_ERR,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic       STREAM_HOLD
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [7:0] REPLY_ACK    = 8'hFA;
  localparam logic [7:0] REPLY_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_CMD_SENT,
    WAIT_CMD_ACK,
    SEND_ARG,
    WAIT_ARG_SENT,
    WAIT_ARG_ACK,
    FINISH
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    cmd_q, arg_q, byte_q;
  logic          arg_vld_q;
  logic          err_q;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] to_cnt;

  logic fin_err, retry_inc, retry_clr;
  logic timed_out, good_rx, ack, resend, can_retry, in_wait;

  assign timed_out = (to_cnt == TO_LAST);
  assign good_rx   = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign ack       = good_rx && (BYTE_READ == REPLY_ACK);
  assign resend    = good_rx && (BYTE_READ == REPLY_RESEND);
  assign can_retry = (retry_cnt < RETRY_MAX);
  assign in_wait   = (state == WAIT_CMD_SENT) || (state == WAIT_CMD_ACK) ||
                     (state == WAIT_ARG_SENT) || (state == WAIT_ARG_ACK);

  always_comb begin
    state_nxt = state;
    fin_err   = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    case (state)
      IDLE: begin
        if (CMD_REQ) begin
          state_nxt = SEND_CMD;
          retry_clr = 1'b1;
        end
      end
      SEND_CMD: state_nxt = WAIT_CMD_SENT;
      SEND_ARG: state_nxt = WAIT_ARG_SENT;
      // Qualifying events are tested before the timeout so they win a tie.
      WAIT_CMD_SENT: begin
        if (BYTE_SENT) begin
          state_nxt = WAIT_CMD_ACK;
        end else if (timed_out) begin
          state_nxt = FINISH;
          fin_err   = 1'b1;
        end
      end
      WAIT_ARG_SENT: begin
        if (BYTE_SENT) begin
          state_nxt = WAIT_ARG_ACK;
        end else if (timed_out) begin
          state_nxt = FINISH;
          fin_err   = 1'b1;
        end
      end
      WAIT_CMD_ACK: begin
        if (BYTE_READY) begin
          if (ack) begin
            // Argument byte gets its own fresh retry budget.
            retry_clr = 1'b1;
            state_nxt = arg_vld_q ? SEND_ARG : FINISH;
          end else if (resend && can_retry) begin
            retry_inc = 1'b1;
            state_nxt = SEND_CMD;
          end else begin
            state_nxt = FINISH;
            fin_err   = 1'b1;
          end
        end else if (timed_out) begin
          state_nxt = FINISH;
          fin_err   = 1'b1;
        end
      end
      WAIT_ARG_ACK: begin
        if (BYTE_READY) begin
          if (ack) begin
            state_nxt = FINISH;
          end else if (resend && can_retry) begin
            retry_inc = 1'b1;
            state_nxt = SEND_ARG;
          end else begin
            state_nxt = FINISH;
            fin_err   = 1'b1;
          end
        end else if (timed_out) begin
          state_nxt = FINISH;
          fin_err   = 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      arg_vld_q <= 1'b0;
      err_q     <= 1'b0;
      retry_cnt <= '0;
      to_cnt    <= '0;
      byte_q    <= 8'hFF;
    end else begin
      state <= state_nxt;

      if (state == IDLE && CMD_REQ) begin
        cmd_q     <= CMD_BYTE;
        arg_q     <= ARG_BYTE;
        arg_vld_q <= ARG_VALID;
      end

      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;

      if (state_nxt != state) to_cnt <= '0;
      else if (in_wait)       to_cnt <= to_cnt + 1'b1;

      if (state_nxt == FINISH && state != FINISH) err_q <= fin_err;

      // Transmit data is loaded on entry to a SEND state and held through the
      // waits; it returns to the idle-line value when the sequence ends.
      if (state_nxt != state) begin
        case (state_nxt)
          SEND_CMD: byte_q <= (state == IDLE) ? CMD_BYTE : cmd_q;
          SEND_ARG: byte_q <= arg_q;
          FINISH:   byte_q <= 8'hFF;
          default:  byte_q <= byte_q;
        endcase
      end
    end
  end

  assign CMD_BUSY     = (state != IDLE);
  assign STREAM_HOLD  = CMD_BUSY;
  assign CMD_DONE     = (state == FINISH);
  assign CMD_ERR      = (state == FINISH) && err_q;
  assign SEND_BYTE    = (state == SEND_CMD) || (state == SEND_ARG);
  assign BYTE_TO_SEND = byte_q;

endmodule

// File: tb/tb_mouse_cmd_sequencer.sv
// Directed testbench for mouse_cmd_sequencer: drives a scripted transmitter and
// receiver, checks strobes, bytes, completion status, timeout and reset abort.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
module tb_mouse_cmd_sequencer;

  localparam int TO = 20;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_req = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic [7:0] arg_byte = 8'h00;
  logic       arg_valid = 1'b0;
  logic       cmd_busy, cmd_done, cmd_err, send_byte, stream_hold;
  logic [7:0] byte_to_send;
  logic       byte_sent = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_read = 8'h00;
  logic [1:0] byte_error_code = 2'b00;

  int checks = 0;
  int failures = 0;
  int n_strobe = 0;
  int n_done = 0;

  mouse_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .CLK(clk), .RESET(reset), .CMD_REQ(cmd_req), .CMD_BYTE(cmd_byte),
    .ARG_BYTE(arg_byte), .ARG_VALID(arg_valid), .CMD_BUSY(cmd_busy),
    .CMD_DONE(cmd_done), .CMD_ERR(cmd_err), .SEND_BYTE(send_byte),
    .BYTE_TO_SEND(byte_to_send), .BYTE_SENT(byte_sent), .BYTE_READY(byte_ready),
    .BYTE_READ(byte_read), .BYTE_ERROR_CODE(byte_error_code), .STREAM_HOLD(stream_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send_byte) n_strobe++;
    if (cmd_done)  n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] c, input logic [7:0] a, input logic av);
    cmd_byte  = c;
    arg_byte  = a;
    arg_valid = av;
    cmd_req   = 1'b1;
    tick();
    cmd_req   = 1'b0;
  endtask

  // Wait for a strobe, check its byte, complete the transmit, then reply.
  // With noise set, an 0xFC arrives while the transmit is still pending.
  task automatic serve(input string tag, input logic [7:0] exp_byte,
                       input logic [7:0] reply, input logic [1:0] code, input bit noise);
    int n = 0;
    while (!send_byte && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_strobe"}, send_byte, 1'b1);
    chk({tag, "_byte"}, byte_to_send, exp_byte);
    tick();
    if (noise) begin
      byte_ready = 1'b1;
      byte_read  = 8'hFC;
      tick();
      byte_ready = 1'b0;
    end
    chk({tag, "_hold"}, byte_to_send, exp_byte);
    byte_sent = 1'b1;
    tick();
    byte_sent       = 1'b0;
    byte_ready      = 1'b1;
    byte_read       = reply;
    byte_error_code = code;
    tick();
    byte_ready      = 1'b0;
    byte_error_code = 2'b00;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int n = 0;
    while (!cmd_done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, cmd_done, 1'b1);
    chk({tag, "_err"}, cmd_err, exp_err);
    tick();
    chk({tag, "_idle"}, cmd_busy, 1'b0);
  endtask

  initial begin
    int s0, d0, n;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", cmd_busy, 1'b0);
    chk("rst_hold", stream_hold, 1'b0);
    chk("rst_done", cmd_done, 1'b0);
    chk("rst_err", cmd_err, 1'b0);
    chk("rst_send", send_byte, 1'b0);
    chk("rst_byte", byte_to_send, 8'hFF);
    reset = 1'b0;
    tick();

    // Minimum latency: REQ in cycle 1, DONE in cycle 5 (4 edges later).
    cmd_byte = 8'hF4; arg_valid = 1'b0; cmd_req = 1'b1;
    tick(); cmd_req = 1'b0;
    chk("lat_busy", cmd_busy, 1'b1);
    chk("lat_hold", stream_hold, 1'b1);
    chk("lat_send", send_byte, 1'b1);
    chk("lat_byte", byte_to_send, 8'hF4);
    tick(); byte_sent = 1'b1;
    tick(); byte_sent = 1'b0; byte_ready = 1'b1; byte_read = 8'hFA;
    tick(); byte_ready = 1'b0;
    chk("lat_done", cmd_done, 1'b1);
    chk("lat_err", cmd_err, 1'b0);
    tick();
    chk("lat_idle", cmd_busy, 1'b0);
    chk("lat_done_pulse", cmd_done, 1'b0);

    // F3 + 28, inputs scrambled and CMD_REQ re-asserted while busy
    s0 = n_strobe;
    start(8'hF3, 8'h28, 1'b1);
    cmd_byte = 8'h00; arg_byte = 8'h00; arg_valid = 1'b0; cmd_req = 1'b1;
    serve("f3_cmd", 8'hF3, 8'hFA, 2'b00, 1'b1);
    cmd_req = 1'b0;
    serve("f3_arg", 8'h28, 8'hFA, 2'b00, 1'b0);
    wait_done("f3", 1'b0);
    chk("f3_strobes", n_strobe - s0, 2);

    // F4 with two resends then ACK
    s0 = n_strobe;
    start(8'hF4, 8'h00, 1'b0);
    serve("rs_1", 8'hF4, 8'hFE, 2'b00, 1'b0);
    serve("rs_2", 8'hF4, 8'hFE, 2'b00, 1'b0);
    serve("rs_3", 8'hF4, 8'hFA, 2'b00, 1'b0);
    wait_done("rs", 1'b0);
    chk("rs_strobes", n_strobe - s0, 3);

    // F4 with four resends exhausts retries
    s0 = n_strobe;
    start(8'hF4, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) serve("rx", 8'hF4, 8'hFE, 2'b00, 1'b0);
    wait_done("rx", 1'b1);
    chk("rx_strobes", n_strobe - s0, 4);

    // E8 02 with no reply to the argument: error TO cycles after WAIT_ARG_ACK
    start(8'hE8, 8'h02, 1'b1);
    serve("to_cmd", 8'hE8, 8'hFA, 2'b00, 1'b0);
    chk("to_arg_strobe", send_byte, 1'b1);
    chk("to_arg_byte", byte_to_send, 8'h02);
    tick(); byte_sent = 1'b1;
    tick(); byte_sent = 1'b0;
    n = 0;
    while (!cmd_done && n < 100) begin
      tick();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_err", cmd_err, 1'b1);
    tick();

    // ACK carrying a receiver error code is a failure
    start(8'hF4, 8'h00, 1'b0);
    serve("ec", 8'hF4, 8'hFA, 2'b01, 1'b0);
    wait_done("ec", 1'b1);

    // Unexpected 0xFC reply is a failure
    start(8'hF4, 8'h00, 1'b0);
    serve("fc", 8'hF4, 8'hFC, 2'b00, 1'b0);
    wait_done("fc", 1'b1);

    // ACK on the terminal timeout cycle wins
    start(8'hF4, 8'h00, 1'b0);
    tick(); byte_sent = 1'b1;
    tick(); byte_sent = 1'b0;
    repeat (TO - 1) tick();
    chk("term_waiting", cmd_busy, 1'b1);
    byte_ready = 1'b1; byte_read = 8'hFA;
    tick(); byte_ready = 1'b0;
    chk("term_done", cmd_done, 1'b1);
    chk("term_err", cmd_err, 1'b0);
    tick();

    // Reset during WAIT_CMD_ACK aborts silently, then a new command completes
    d0 = n_done;
    start(8'hF4, 8'h00, 1'b0);
    tick(); byte_sent = 1'b1;
    tick(); byte_sent = 1'b0;
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("ra_busy", cmd_busy, 1'b0);
    chk("ra_byte", byte_to_send, 8'hFF);
    repeat (3) tick();
    chk("ra_no_done", n_done - d0, 0);
    start(8'hF4, 8'h00, 1'b0);
    serve("ra_new", 8'hF4, 8'hFA, 2'b00, 1'b0);
    wait_done("ra_new", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
